uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised UART transmitter with an input FIFO, valid/ready handshake, programmable baud divider, configurable word length, stop bits and parity mode. It is the next-generation serial transmit path: a host-side producer pushes words, and the block serialises them onto `tx` back-to-back, with no lost words and no idle gap while data is queued. It sits between the on-chip bus/producer and the pad driver.

## Interface
- `DATA_W`, 8: bits per word, legal 5..9.
- `FIFO_DEPTH`, 4: FIFO entries, power of two, ≥2.
- `CLKS_PER_BIT`, 16: clk cycles per serial bit, ≥2.
- `STOP_BITS`, 1: 1 or 2.
- `clk`  in  1  clock.
- `rst`  in  1  reset: asynchronous, active-high.
- `s_valid`  in  1  producer has a word.
- `s_data`  in  DATA_W  word to send.
- `s_ready`  out  1  FIFO can accept; equals `!full`.
- `parity_mode`  in  2  00 none, 01 even, 10 odd, 11 treated as none.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  FSM not in IDLE or FIFO not empty.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  occupied entries.

## Operation
- Push on rising `clk` when `s_valid && s_ready`; `s_data` captured that edge. No bypass: a push into an empty FIFO still goes through the FIFO.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: `tx`=1. If FIFO non-empty, pop, load shift register with the head word, latch `parity_mode`, compute the parity bit, go to START.
- START: `tx`=0 for one bit time, then DATA.
- DATA: LSB first, DATA_W bits, then PARITY if the latched mode is even/odd, otherwise STOP.
- PARITY: even mode sends XOR of the word; odd mode sends its inverse.
- STOP: `tx`=1 for STOP_BITS bit times. At the end, if FIFO is non-empty, pop and go directly to START (no idle bit); otherwise go to IDLE.
- Bit timer: counts 0..CLKS_PER_BIT-1; every bit is held exactly CLKS_PER_BIT cycles. A bit index counter covers DATA and the stop bits.
- `parity_mode` changes mid-frame do not affect the frame in flight.
- Simultaneous push and pop: both happen; `fifo_count` is unchanged.
- Push while full: impossible by handshake (`s_ready`=0); `s_valid` is held by the producer.
- Reset at any time, including mid-frame: `tx`=1 immediately, FSM to IDLE, FIFO flushed, frame truncated.
- Reset values: `tx`=1, `busy`=0, `fifo_count`=0, `s_ready`=1.

## Timing
- `tx` is registered.
- Push at edge N into an empty FIFO with FSM idle: pop at edge N+1, `tx` falls at N+1.
- Frame length: (1 + DATA_W + P + STOP_BITS) × CLKS_PER_BIT cycles, where P=1 if parity is active.
- Back-to-back frames: the next start bit begins on the edge after the last stop-bit cycle.
- `s_ready` and `fifo_count` reflect the registered FIFO state. `s_ready` rises the cycle after a pop from full.

## Configuration
- `UART_TX_PARITY_EN` defined: parity is supported as described above.
- Not defined: the PARITY state and parity logic are not built. `parity_mode` is ignored and frames are always start + data + stop.

## Structure
- Shared package `uart_pkg` holds:
  - `parity_mode_t` enum (PAR_NONE, PAR_EVEN, PAR_ODD).
  - `uart_tx_state_t` enum.
  - Constants for idle, start and stop line levels.
- One sub-module, `uart_sync_fifo`: parametrised synchronous FIFO with push, pop, full, empty and count.

## Test plan
- DATA_W=8, CLKS_PER_BIT=4, even parity, push 0xA5 → `tx` = 0,1,0,1,0,0,1,0,1,0,1, each bit held 4 cycles, 44 cycles total, then `busy`=0.
- Odd parity, push 0x01 → parity bit 0. Even parity, push 0x01 → parity bit 1. `parity_mode`=11 → no parity bit, 40-cycle frame.
- FIFO_DEPTH=4, push 6 words back-to-back → word 1 popped at once, `fifo_count` reaches 4, `s_ready`=0 for word 6 until the first frame ends. All 6 words appear in order with no idle gap.
- STOP_BITS=2, push 0x00 → `tx` high for 8 cycles after the data bits. The next queued word's start bit follows immediately.
- Assert `rst` 10 cycles into a frame with 2 words queued → `tx`=1, `busy`=0, `fifo_count`=0 in the same cycle. After release, `tx` stays idle.
- Build without `UART_TX_PARITY_EN`, even mode, push 0xA5 → 40-cycle frame with no parity bit.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and line levels for the UART transmit path.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_tx_state_t;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO. Registered occupancy and pointers; the head word is read combinationally.
// A push while full or a pop while empty is ignored.
module uart_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; the pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO; frames go back-to-back while words are queued.
// Parity bit is built only when UART_TX_PARITY_EN is defined; otherwise parity_mode is ignored.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  input  logic [DATA_W-1:0]             s_data,
  output logic                          s_ready,
  input  logic [1:0]                    parity_mode,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W);

  uart_tx_state_t    state_q, state_d;
  logic              tx_q, tx_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [BW-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_en_q, par_en_d, par_bit_q, par_bit_d;

  logic              fifo_full, fifo_empty, pop, load, bit_end;
  logic [DATA_W-1:0] fifo_rdata;

  uart_sync_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s_valid),
    .wdata (s_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign s_ready = !fifo_full;
  assign busy    = (state_q != ST_IDLE) || !fifo_empty;
  assign tx      = tx_q;
  assign bit_end = (timer_q == TW'(CLKS_PER_BIT - 1));

`ifdef UART_TX_PARITY_EN
  // Mode and parity are captured at pop so mid-frame mode changes cannot disturb the frame.
  assign par_en_d  = load ? (parity_mode == PAR_EVEN || parity_mode == PAR_ODD) : par_en_q;
  assign par_bit_d = load ? ((^fifo_rdata) ^ (parity_mode == PAR_ODD)) : par_bit_q;
`else
  logic unused_parity_mode;
  assign unused_parity_mode = ^parity_mode;
  assign par_en_d  = 1'b0;
  assign par_bit_d = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    load      = 1'b0;
    timer_d   = (state_q == ST_IDLE || bit_end) ? '0 : timer_q + TW'(1);
    case (state_q)
      ST_IDLE: begin
        tx_d = LINE_IDLE;
        load = !fifo_empty;
      end
      ST_START: if (bit_end) begin
        state_d   = ST_DATA;
        tx_d      = shift_q[0];
        bit_idx_d = '0;
      end
      ST_DATA: if (bit_end) begin
        if (bit_idx_q == BW'(DATA_W - 1)) begin
          if (par_en_q) begin
            state_d = ST_PARITY;
            tx_d    = par_bit_q;
          end else begin
            state_d   = ST_STOP;
            tx_d      = LINE_STOP;
            bit_idx_d = '0;
          end
        end else begin
          bit_idx_d = bit_idx_q + BW'(1);
          shift_d   = shift_q >> 1;
          tx_d      = shift_q[1];
        end
      end
      ST_PARITY: if (bit_end) begin
        state_d   = ST_STOP;
        tx_d      = LINE_STOP;
        bit_idx_d = '0;
      end
      ST_STOP: if (bit_end) begin
        if (bit_idx_q == BW'(STOP_BITS - 1)) begin
          if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            state_d = ST_IDLE;
            tx_d    = LINE_IDLE;
          end
        end else begin
          bit_idx_d = bit_idx_q + BW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = LINE_IDLE;
      end
    endcase
    // Loading from IDLE or straight out of the last stop bit starts the next frame with no gap.
    if (load) begin
      shift_d = fifo_rdata;
      state_d = ST_START;
      tx_d    = LINE_START;
      timer_d = '0;
    end
  end

  assign pop = load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tx_q      <= LINE_IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: scoreboard of expected frames checked cycle by cycle on tx.
// Two instances: STOP_BITS=1 (dut 0) and STOP_BITS=2 (dut 1).
module tb_uart_tx_fifo;

  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif

  typedef struct {
    logic [15:0] bits;
    int          n;
  } frame_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       parity_mode = 2'b00;
  logic [1:0]       s_valid = 2'b00;
  logic [1:0][7:0]  s_data = '0;
  logic [1:0]       s_ready_w, tx_w, busy_w;
  logic [1:0][2:0]  cnt_w;

  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0;

  frame_t exp_q [2][$];
  int     start_q [2][$];
  int     done_cnt [2];
  bit     active [2];
  int     idx [2];
  int     quiet [2];
  frame_t cur [2];
  logic [15:0] got [2];
  bit     mism [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  uart_tx_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .CLKS_PER_BIT(C), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .s_valid(s_valid[0]), .s_data(s_data[0]), .s_ready(s_ready_w[0]),
    .parity_mode(parity_mode), .tx(tx_w[0]), .busy(busy_w[0]), .fifo_count(cnt_w[0]));

  uart_tx_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .CLKS_PER_BIT(C), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .s_valid(s_valid[1]), .s_data(s_data[1]), .s_ready(s_ready_w[1]),
    .parity_mode(parity_mode), .tx(tx_w[1]), .busy(busy_w[1]), .fifo_count(cnt_w[1]));

  function automatic frame_t build(input logic [7:0] w, input logic [1:0] m, input int stops);
    frame_t f;
    f.bits = '0;
    f.n = 0;
    f.bits[f.n] = 1'b0; f.n++;
    for (int i = 0; i < 8; i++) begin f.bits[f.n] = w[i]; f.n++; end
    if (PAR_BUILT && (m == 2'b01 || m == 2'b10)) begin
      f.bits[f.n] = (m == 2'b01) ? ^w : ~^w; f.n++;
    end
    for (int i = 0; i < stops; i++) begin f.bits[f.n] = 1'b1; f.n++; end
    return f;
  endfunction

  function automatic int flen(input int stops, input logic [1:0] m);
    return (9 + ((PAR_BUILT && (m == 2'b01 || m == 2'b10)) ? 1 : 0) + stops) * C;
  endfunction

  task automatic run_monitor();
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rst) begin
          active[d] = 1'b0;
          exp_q[d].delete();
        end else begin
          if (quiet[d] > 0) quiet[d]--;
          if (!active[d] && quiet[d] == 0 && tx_w[d] === 1'b0) begin
            if (exp_q[d].size() == 0) begin
              checks++; failures++;
              $display("FAIL unexpected_frame dut%0d: start bit at cycle %0d with no word expected", d, cyc_cnt);
              quiet[d] = 64;
            end else begin
              cur[d] = exp_q[d].pop_front();
              active[d] = 1'b1; idx[d] = 0; got[d] = '0; mism[d] = 1'b0;
              start_q[d].push_back(cyc_cnt);
            end
          end
          if (active[d]) begin
            if (tx_w[d] !== cur[d].bits[idx[d] / C]) mism[d] = 1'b1;
            if (idx[d] % C == C / 2) got[d][idx[d] / C] = tx_w[d];
            idx[d]++;
            if (idx[d] == cur[d].n * C) begin
              checks++;
              if (mism[d] || got[d] !== cur[d].bits) begin
                failures++;
                $display("FAIL frame dut%0d: got bits %b (per-cycle deviation=%0d) expected %b", d, got[d], mism[d], cur[d].bits);
              end
              active[d] = 1'b0;
              done_cnt[d]++;
            end
          end
        end
      end
    end
  endtask

  // Leaves s_valid asserted after the accepting edge so consecutive calls push back-to-back.
  task automatic push_word(input int d, input logic [7:0] w, output int acc, output int stall);
    stall = 0;
    s_valid[d] = 1'b1;
    s_data[d] = w;
    while (!s_ready_w[d] && stall < 400) begin @(negedge clk); stall++; end
    checks++;
    if (!s_ready_w[d]) begin
      failures++;
      $display("FAIL push_timeout dut%0d: s_ready=%b after %0d cycles, required 1", d, s_ready_w[d], stall);
    end
    exp_q[d].push_back(build(w, parity_mode, d == 0 ? 1 : 2));
    acc = cyc_cnt + 1;
    @(negedge clk);
  endtask

  task automatic wait_done(input int d, input int target);
    int n = 0;
    while (done_cnt[d] < target && n < 3000) begin @(posedge clk); #1; n++; end
    checks++;
    if (done_cnt[d] < target) begin
      failures++;
      $display("FAIL frame_timeout dut%0d: frames done %0d, required %0d", d, done_cnt[d], target);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (tx_w[0] !== 1'b1)   begin failures++; $display("FAIL reset_tx: got %b required 1", tx_w[0]); end
    checks++; if (busy_w[0] !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy_w[0]); end
    checks++; if (cnt_w[0] !== 3'd0)  begin failures++; $display("FAIL reset_count: got %0d required 0", cnt_w[0]); end
    checks++; if (s_ready_w[0] !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b required 1", s_ready_w[0]); end
  endtask

  task automatic test_parity();
    logic [7:0] words [4] = '{8'hA5, 8'h01, 8'h01, 8'h01};
    logic [1:0] modes [4] = '{2'b01, 2'b10, 2'b01, 2'b11};
    int acc, stall, base;
    for (int i = 0; i < 4; i++) begin
      parity_mode = modes[i];
      start_q[0].delete();
      base = done_cnt[0];
      @(negedge clk);
      push_word(0, words[i], acc, stall);
      s_valid[0] = 1'b0;
      wait_done(0, base + 1);
      checks++;
      if (busy_w[0] !== 1'b0) begin failures++; $display("FAIL parity%0d_busy_after: got %b required 0", i, busy_w[0]); end
      checks++;
      if (start_q[0].size() != 1 || start_q[0][0] != acc + 1) begin
        failures++;
        $display("FAIL parity%0d_latency: start cycle %0d required %0d", i, start_q[0].size() > 0 ? start_q[0][0] : -1, acc + 1);
      end
    end
  endtask

  task automatic test_mode_change();
    int acc, stall, base;
    parity_mode = 2'b01;
    base = done_cnt[0];
    @(negedge clk);
    push_word(0, 8'h01, acc, stall);
    s_valid[0] = 1'b0;
    repeat (10) @(negedge clk);
    parity_mode = 2'b10;
    wait_done(0, base + 1);
    parity_mode = 2'b01;
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [6] = '{8'h11, 8'hC3, 8'h7E, 8'h80, 8'h3C, 8'hF0};
    int acc [6];
    int stall [6];
    int base, bad;
    parity_mode = 2'b01;
    start_q[0].delete();
    base = done_cnt[0];
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      push_word(0, words[i], acc[i], stall[i]);
      if (i == 4) begin
        checks++;
        if (cnt_w[0] !== 3'd4 || s_ready_w[0] !== 1'b0) begin
          failures++;
          $display("FAIL b2b_full: count %0d ready %b, required count 4 ready 0", cnt_w[0], s_ready_w[0]);
        end
      end
    end
    s_valid[0] = 1'b0;
    wait_done(0, base + 6);
    checks++;
    if (stall[5] == 0) begin failures++; $display("FAIL b2b_stall: word 6 stalled %0d cycles, required >0", stall[5]); end
    checks++;
    if (start_q[0].size() < 2 || acc[5] != start_q[0][1] + 1) begin
      failures++;
      $display("FAIL b2b_ready_rise: word 6 accepted at %0d, required %0d", acc[5], start_q[0].size() > 1 ? start_q[0][1] + 1 : -1);
    end
    checks++;
    if (start_q[0].size() < 1 || start_q[0][0] != acc[0] + 1) begin
      failures++;
      $display("FAIL b2b_first_latency: start %0d required %0d", start_q[0].size() > 0 ? start_q[0][0] : -1, acc[0] + 1);
    end
    bad = 0;
    for (int i = 1; i < start_q[0].size(); i++)
      if (start_q[0][i] - start_q[0][i-1] != flen(1, 2'b01)) bad++;
    checks++;
    if (bad != 0 || start_q[0].size() != 6) begin
      failures++;
      $display("FAIL b2b_gaps: %0d irregular gaps over %0d frames, required 0 over 6", bad, start_q[0].size());
    end
  endtask

  task automatic test_stop2();
    int acc, stall, base;
    parity_mode = 2'b00;
    start_q[1].delete();
    base = done_cnt[1];
    @(negedge clk);
    push_word(1, 8'h00, acc, stall);
    push_word(1, 8'h5A, acc, stall);
    s_valid[1] = 1'b0;
    wait_done(1, base + 2);
    checks++;
    if (start_q[1].size() != 2 || start_q[1][1] - start_q[1][0] != flen(2, 2'b00)) begin
      failures++;
      $display("FAIL stop2_gap: %0d frames, gap %0d, required 2 frames gap %0d", start_q[1].size(),
               start_q[1].size() == 2 ? start_q[1][1] - start_q[1][0] : -1, flen(2, 2'b00));
    end
    checks++;
    if (busy_w[1] !== 1'b0) begin failures++; $display("FAIL stop2_busy_after: got %b required 0", busy_w[1]); end
  endtask

  task automatic test_reset_mid();
    int acc, stall, n, bad;
    parity_mode = 2'b01;
    start_q[0].delete();
    @(negedge clk);
    for (int i = 0; i < 3; i++) push_word(0, 8'h40 + 8'(i), acc, stall);
    s_valid[0] = 1'b0;
    n = 0;
    while (start_q[0].size() == 0 && n < 100) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++; if (tx_w[0] !== 1'b1)   begin failures++; $display("FAIL midrst_tx: got %b required 1", tx_w[0]); end
    checks++; if (busy_w[0] !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b required 0", busy_w[0]); end
    checks++; if (cnt_w[0] !== 3'd0)  begin failures++; $display("FAIL midrst_count: got %0d required 0", cnt_w[0]); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL midrst_idle_after: %0d non-idle cycles, required 0", bad); end
  endtask

  task automatic test_drain();
    checks++;
    if (exp_q[0].size() != 0 || exp_q[1].size() != 0 || active[0] || active[1]) begin
      failures++;
      $display("FAIL drain: pending %0d/%0d active %b/%b, required none", exp_q[0].size(), exp_q[1].size(), active[0], active[1]);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      done_cnt[d] = 0; active[d] = 1'b0; idx[d] = 0; quiet[d] = 0; mism[d] = 1'b0; got[d] = '0;
    end
    fork
      run_monitor();
      begin
        test_reset();
        test_parity();
        test_mode_change();
        test_back_to_back();
        test_stop2();
        test_reset_mid();
        test_drain();
      end
    join_any
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
